// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Read-side controller for a synchronous fifo with a 1-cycle
//                registered read port (empty / rd_en / dout). Words pulled
//                from the fifo are presented on a valid/ready stream. A
//                2-entry skid buffer absorbs the read latency, so one word
//                per clock is delivered when there is no backpressure.
//                Delivered words are counted.
//
//  Ports
//    clk         in   1          single clock, rising edge
//    rst         in   1          asynchronous active-high reset
//    en          in   1          1 = allowed to issue new fifo reads
//    fifo_empty  in   1          fifo empty flag (sampled combinationally)
//    fifo_rd_en  out  1          read strobe to the fifo (combinational)
//    fifo_dout   in   WIDTH      fifo read data, valid the clock after rd_en
//    m_valid     out  1          stream data valid (registered)
//    m_ready     in   1          downstream accepts m_data
//    m_data      out  WIDTH      stream data, head of the skid buffer
//    word_cnt    out  CNT_WIDTH  words delivered since reset (wraps)
//
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam logic [1:0] c_max_after_issue = 2'd1;

    // ------------------------------------------------------------------------
    // State
    //   r_occ       : entries currently held in the skid buffer (0..2)
    //   r_in_flight : a fifo read was issued on the previous clock, so
    //                 fifo_dout carries a word that must be captured now
    //   r_head      : entry presented on m_data
    //   r_tail      : entry the next captured word is written to
    // ------------------------------------------------------------------------
    logic [1:0]           r_occ;
    logic                 r_in_flight;
    logic                 r_head;
    logic                 r_tail;
    logic [WIDTH-1:0]     r_entry [2];
    logic                 r_m_valid;
    logic [CNT_WIDTH-1:0] r_word_cnt;

    logic                 w_pop;
    logic [1:0]           w_level;

    // A word leaves the buffer on every accepted stream beat.
    assign w_pop = r_m_valid & m_ready;

    // Buffer level after this edge if no new read were issued. It also is the
    // next-state occupancy, because an in-flight word always lands this edge.
    // The invariant occ + in_flight <= 2 keeps this within 0..2, so 2 bits
    // suffice and the subtraction never underflows (pop implies occ >= 1).
    assign w_level = r_occ + {1'b0, r_in_flight} - {1'b0, w_pop};

    // Issue a read only when the word it returns next clock is guaranteed a
    // free slot: the level after this edge must leave room for one more.
    // rst gates the strobe so nothing is pulled from the fifo during reset.
    assign fifo_rd_en = en & ~fifo_empty & ~rst & (w_level <= c_max_after_issue);

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ       <= 2'd0;
            r_in_flight <= 1'b0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_m_valid   <= 1'b0;
        end else begin
            r_in_flight <= fifo_rd_en;
            r_occ       <= w_level;
            // Registered copy of (occ != 0) for the next cycle.
            r_m_valid   <= (w_level != 2'd0);
            if (r_in_flight) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Skid buffer storage. Only the tail entry is written, so the head entry
    // (and therefore m_data) stays stable while the stream is stalled.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry[0] <= '0;
            r_entry[1] <= '0;
        end else if (r_in_flight) begin
            r_entry[r_tail] <= fifo_dout;
        end
    end

    // ------------------------------------------------------------------------
    // Delivered-word counter, wraps naturally at 2^CNT_WIDTH.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
        end
    end

    assign m_valid  = r_m_valid;
    assign m_data   = r_entry[r_head];
    assign word_cnt = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Self-checking bench for fifo_stream_reader. A behavioural
//                depth-8 fifo (active-low reset driven by ~rst) feeds the
//                reader; a scoreboard queue holds every word accepted by the
//                fifo and a monitor compares each stream beat against it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 5;   // small so the wrap of word_cnt is reached
    localparam int DEPTH     = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [WIDTH-1:0]     fifo_dout;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [WIDTH-1:0]     m_data;
    logic [CNT_WIDTH-1:0] word_cnt;

    logic                 wr_en = 1'b0;
    logic [WIDTH-1:0]     wr_data = '0;
    logic                 fifo_rst_n;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .word_cnt   (word_cnt)
    );

    // ------------------------------------------------------------------------
    // Behavioural synchronous fifo: registered read data, active-low reset.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] fq [$];
    int               fcount = 0;

    assign fifo_rst_n = ~rst;
    assign fifo_empty = (fcount == 0);

    always @(posedge clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            fq.delete();
            fcount    <= 0;
            fifo_dout <= '0;
        end else begin
            if (fifo_rd_en && fcount > 0) begin
                fifo_dout <= fq[0];
                void'(fq.pop_front());
            end
            if (wr_en && fcount < DEPTH) begin
                fq.push_back(wr_data);
            end
            fcount <= fcount + ((wr_en && fcount < DEPTH) ? 1 : 0)
                             - ((fifo_rd_en && fcount > 0) ? 1 : 0);
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard / monitor state (written only by the monitor process)
    // ------------------------------------------------------------------------
    int               n_cmp  = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] exp_q [$];
    int               exp_cnt = 0;
    int               outst = 0;
    int               rd_total = 0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    // Requests from the stimulus for one-off comparisons
    int               chk_seq = 0;
    int               chk_seen = 0;
    string            chk_name = "";
    int               chk_act = 0;
    int               chk_exp = 0;
    bit               tb_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    initial begin : monitor
        logic [WIDTH-1:0] w_exp;
        bit               hs;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                check("rst_m_valid",  32'(m_valid),    32'd0);
                check("rst_rd_en",    32'(fifo_rd_en), 32'd0);
                check("rst_word_cnt", 32'(word_cnt),   32'd0);
                check("rst_m_data",   32'(m_data),     32'd0);
                exp_q.delete();
                exp_cnt    = 0;
                outst      = 0;
                prev_stall = 1'b0;
            end else begin
                if (chk_seq != chk_seen) begin
                    check(chk_name, 32'(chk_act), 32'(chk_exp));
                    chk_seen = chk_seq;
                end
                check("word_cnt", 32'(word_cnt), 32'(exp_cnt));
                if (prev_stall) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_data",  32'(m_data),  32'(prev_data));
                end
                if (fifo_rd_en) begin
                    check("rd_when_empty", 32'(fifo_empty), 32'd0);
                end
                hs = m_valid && m_ready;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %0h expected none (t=%0t)", m_data, $time);
                    end else begin
                        w_exp = exp_q.pop_front();
                        check("data_order", 32'(m_data), 32'(w_exp));
                    end
                    exp_cnt = (exp_cnt + 1) % (1 << CNT_WIDTH);
                end
                outst = outst + (fifo_rd_en ? 1 : 0) - (hs ? 1 : 0);
                if (fifo_rd_en) begin
                    check("outstanding_le2", 32'(outst <= 2), 32'd1);
                end
                if (wr_en && fcount < DEPTH) begin
                    exp_q.push_back(wr_data);
                end
                if (fifo_rd_en) begin
                    rd_total++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                if (tb_done) begin
                    check("leftover_words", 32'(exp_q.size()), 32'd0);
                    check("fifo_left",      32'(fcount),       32'd0);
                    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                    $finish;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand a comparison to the monitor; call at posedge+1.
    task automatic req(input string name, input int act, input int expv);
        chk_name = name;
        chk_act  = act;
        chk_exp  = expv;
        chk_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        en      = 1'b1;
        m_ready = 1'b1;
        wr_en   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (exp_q.size() == 0 && fcount == 0 && !m_valid) break;
        end
        tick();
    endtask

    initial begin : stimulus
        logic [WIDTH-1:0] t2w [3];
        int base;
        int run;
        int maxrun;
        int hsrun;
        int maxhs;
        int got;
        int cyc;
        int n;

        t2w[0] = 16'h00A1;
        t2w[1] = 16'h00B2;
        t2w[2] = 16'h00C3;

        // Reset held for a few clocks
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Three words, full throughput
        en = 1'b1;
        m_ready = 1'b1;
        base = rd_total;
        run = 0; maxrun = 0; hsrun = 0; maxhs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            wr_en   = (i < 3);
            wr_data = (i < 3) ? t2w[i] : '0;
            #3;
            run   = fifo_rd_en ? run + 1 : 0;
            hsrun = (m_valid && m_ready) ? hsrun + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (hsrun > maxhs) maxhs = hsrun;
        end
        tick();
        req("t2_rd_pulses", rd_total - base, 3);
        req("t2_rd_consecutive", maxrun, 3);
        req("t2_data_consecutive", maxhs, 3);
        req("t2_word_cnt", int'(word_cnt), 3);

        // Fill with backpressure: exactly two reads, six words left behind
        m_ready = 1'b0;
        base = rd_total;
        for (int i = 0; i < 9; i++) begin
            tick();
            wr_en   = (i < 8);
            wr_data = WIDTH'($urandom);
        end
        repeat (6) tick();
        req("t3_rd_pulses", rd_total - base, 2);
        req("t3_fifo_left", fcount, 6);
        tick();
        m_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 20) begin
            #3;
            if (m_valid) got++;
            cyc++;
            tick();
        end
        req("t3_drain_cycles", cyc, 8);
        drain();

        // Toggling backpressure
        for (int i = 0; i < 30; i++) begin
            tick();
            wr_en   = (i < 8);
            wr_data = WIDTH'($urandom);
            m_ready = (i % 2) == 1;
        end
        drain();

        // en dropped after the third read
        en = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            wr_en   = (i < 8);
            wr_data = WIDTH'($urandom);
        end
        tick();
        base = rd_total;
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (fifo_rd_en) n++;
            tick();
            if (n == 3) break;
        end
        en = 1'b0;
        repeat (10) tick();
        req("t5_rd_paused", rd_total - base, 3);
        req("t5_fifo_left", fcount, 5);
        req("t5_pending", exp_q.size(), 5);
        drain();

        // Asynchronous reset in the middle of a stream
        en = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            wr_en   = (i < 4);
            wr_data = WIDTH'($urandom);
        end
        repeat (4) tick();
        @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        m_ready = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h1234;
        tick();
        wr_en = 1'b0;
        repeat (6) tick();
        req("t6_first_word_cnt", int'(word_cnt), 1);
        drain();

        // Randomised traffic
        for (int i = 0; i < 200; i++) begin
            tick();
            en      = ($urandom % 5) != 0;
            m_ready = ($urandom % 10) < 7;
            wr_en   = ($urandom % 2) == 1;
            wr_data = WIDTH'($urandom);
        end
        drain();

        tb_done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL end_of_test: got no summary expected summary");
        $fatal(1, "monitor did not finish");
    end

endmodule
`default_nettype wire
